// File: rtl/ofdmbbp_cmd_sched_pkg.sv
// Shared types for the OFDM baseband command scheduler: state encoding, field widths, command word layout.
package ofdmbbp_sched_pkg;

    localparam int LEN_W   = 8;
    localparam int PAUSE_W = 22;
    localparam int MODE_W  = 2;
    localparam int CMD_W   = PAUSE_W + MODE_W + LEN_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    typedef struct packed {
        logic [PAUSE_W-1:0] pause;
        logic [MODE_W-1:0]  mode;
        logic [LEN_W-1:0]   length;
    } cmd_t;

endpackage

// File: rtl/ofdmbbp_cmd_sched_if.sv
// Scheduler port bundle: command FIFO side, core command/data handshakes, control inputs and status outputs.
interface ofdmbbp_cmd_sched_if #(
    parameter int DATA_W  = 24,
    parameter int LEN_W   = 8,
    parameter int PAUSE_W = 22,
    parameter int MODE_W  = 2
);
    logic                            enable;
    logic                            hold;
    logic                            abort;
    logic                            src_cmd_valid;
    logic                            src_cmd_ready;
    logic [PAUSE_W+MODE_W+LEN_W-1:0] src_cmd_bits;
    logic                            core_cmd_valid;
    logic                            core_cmd_ready;
    logic [LEN_W-1:0]                core_cmd_length;
    logic [MODE_W-1:0]               core_cmd_mode;
    logic [PAUSE_W-1:0]              core_cmd_pause;
    logic                            src_din_valid;
    logic                            src_din_ready;
    logic [DATA_W-1:0]               src_din_bits;
    logic                            core_din_valid;
    logic                            core_din_ready;
    logic [DATA_W-1:0]               core_din_bits;
    logic                            busy;
    logic [1:0]                      state;
    logic                            cmd_done;
    logic [15:0]                     cmd_count;
    logic [15:0]                     starve_count;

    modport master (
        output enable, hold, abort, src_cmd_valid, src_cmd_bits, core_cmd_ready,
               src_din_valid, src_din_bits, core_din_ready,
        input  src_cmd_ready, core_cmd_valid, core_cmd_length, core_cmd_mode, core_cmd_pause,
               src_din_ready, core_din_valid, core_din_bits, busy, state, cmd_done,
               cmd_count, starve_count
    );

    modport slave (
        input  enable, hold, abort, src_cmd_valid, src_cmd_bits, core_cmd_ready,
               src_din_valid, src_din_bits, core_din_ready,
        output src_cmd_ready, core_cmd_valid, core_cmd_length, core_cmd_mode, core_cmd_pause,
               src_din_ready, core_din_valid, core_din_bits, busy, state, cmd_done,
               cmd_count, starve_count
    );

endinterface

// File: rtl/ofdmbbp_cmd_sched_stats.sv
// Completed-command counter (wrapping) and core-starvation cycle counter (saturating at 0xFFFF).
module ofdmbbp_sched_stats (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_done,
    input  logic        i_starve,
    output logic [15:0] o_cmd_count,
    output logic [15:0] o_starve_count
);

    logic [15:0] r_cmd_count;
    logic [15:0] r_starve_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cmd_count    <= 16'd0;
            r_starve_count <= 16'd0;
        end else begin
            if (i_done) begin
                r_cmd_count <= r_cmd_count + 16'd1;
            end
            if (i_starve && (r_starve_count != 16'hFFFF)) begin
                r_starve_count <= r_starve_count + 16'd1;
            end
        end
    end

    assign o_cmd_count    = r_cmd_count;
    assign o_starve_count = r_starve_count;

endmodule

// File: rtl/ofdmbbp_cmd_sched.sv
// Presents one command to the OFDM core, gates exactly `length` data beats through, then idles `pause` cycles.
// Statistics counters exist only when OFDMBBP_SCHED_STATS_EN is defined; otherwise they read as 0.
module ofdmbbp_cmd_sched #(
    parameter int DATA_W  = 24,
    parameter int PAUSE_W = 22,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rstn,
    ofdmbbp_cmd_sched_if.slave bus
);
    import ofdmbbp_sched_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    cmd_t               r_cmd;
    cmd_t               w_cmd;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic [PAUSE_W-1:0] r_pause_cnt;
    logic               r_cmd_done;
    logic               w_run;
    logic               w_cmd_fire;
    logic               w_din_fire;
    logic               w_done;
    logic               w_load_pause;

    assign w_cmd = bus.src_cmd_bits;

    // Abort also masks both FIFO pops so an abort cycle never swallows a command or a data word.
    assign bus.src_cmd_ready = rstn & bus.enable & ~bus.hold & ~bus.abort & (r_state == S_IDLE);
    assign w_run             = (r_state == S_RUN) & ~bus.abort;
    assign w_cmd_fire        = bus.src_cmd_valid & bus.src_cmd_ready;
    assign w_din_fire        = w_run & bus.src_din_valid & bus.core_din_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_done       = 1'b0;
        w_load_pause = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.core_cmd_ready) begin
                    if (r_cmd.length != '0) begin
                        w_state_nxt = S_RUN;
                    end else if (r_cmd.pause != '0) begin
                        w_state_nxt  = S_PAUSE;
                        w_load_pause = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_din_fire && (r_beat_cnt == LEN_W'(1))) begin
                    if (r_cmd.pause != '0) begin
                        w_state_nxt  = S_PAUSE;
                        w_load_pause = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done      = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (r_pause_cnt <= PAUSE_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.abort) begin
            w_state_nxt  = S_IDLE;
            w_done       = 1'b0;
            w_load_pause = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_beat_cnt  <= '0;
            r_pause_cnt <= '0;
            r_cmd_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_done <= w_done;
            if (bus.abort) begin
                r_beat_cnt  <= '0;
                r_pause_cnt <= '0;
            end else begin
                if (w_cmd_fire) begin
                    r_cmd      <= w_cmd;
                    r_beat_cnt <= w_cmd.length;
                end else if (w_din_fire) begin
                    r_beat_cnt <= r_beat_cnt - 1'b1;
                end
                if (w_load_pause) begin
                    r_pause_cnt <= r_cmd.pause;
                end else if (r_state == S_PAUSE) begin
                    r_pause_cnt <= r_pause_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.core_cmd_valid  = (r_state == S_ISSUE);
    assign bus.core_cmd_length = r_cmd.length;
    assign bus.core_cmd_mode   = r_cmd.mode;
    assign bus.core_cmd_pause  = r_cmd.pause;
    assign bus.core_din_valid  = w_run & bus.src_din_valid;
    assign bus.src_din_ready   = w_run & bus.core_din_ready;
    assign bus.core_din_bits   = w_run ? bus.src_din_bits : {DATA_W{1'b0}};
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.state           = r_state;
    assign bus.cmd_done        = r_cmd_done;

`ifdef OFDMBBP_SCHED_STATS_EN
    logic w_starve;
    assign w_starve = (r_state == S_RUN) & bus.core_din_ready & ~bus.src_din_valid;

    ofdmbbp_sched_stats u_stats (
        .clk            (clk),
        .rstn           (rstn),
        .i_done         (w_done),
        .i_starve       (w_starve),
        .o_cmd_count    (bus.cmd_count),
        .o_starve_count (bus.starve_count)
    );
`else
    assign bus.cmd_count    = 16'd0;
    assign bus.starve_count = 16'd0;
`endif

endmodule

// File: tb/tb_ofdmbbp_cmd_sched.sv
// Directed bench for ofdmbbp_cmd_sched: command table plus hand sequences for starvation, abort, hold and enable.
`timescale 1ns/1ps
module tb_ofdmbbp_cmd_sched;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

`ifdef OFDMBBP_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    ofdmbbp_cmd_sched_if #(.DATA_W(24), .LEN_W(8), .PAUSE_W(22), .MODE_W(2)) bus ();

    ofdmbbp_cmd_sched #(.DATA_W(24), .PAUSE_W(22), .LEN_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic [21:0] pause;
        logic [1:0]  mode;
        logic [7:0]  len;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t        vecs[6];
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          cyc_no     = 0;
    int          n_din_fire = 0;
    int          n_cmd_fire = 0;
    int          bits_bad   = 0;
    int          exp_cnt    = 0;
    logic        last_cmd_fire = 1'b0;
    logic [23:0] data_q[$];
    logic [23:0] wseed = 24'h5A0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; samples handshakes just before the rising edge, returns at the next falling edge.
    task automatic cyc();
        logic fd;
        logic fc;
        bus.src_din_valid = (data_q.size() != 0);
        bus.src_din_bits  = (data_q.size() != 0) ? data_q[0] : 24'h0;
        #2;
        fd = bus.src_din_valid & bus.src_din_ready;
        fc = bus.src_cmd_valid & bus.src_cmd_ready;
        if (fd && ((bus.core_din_bits !== data_q[0]) || (bus.core_din_valid !== 1'b1))) bits_bad++;
        @(posedge clk);
        if (fd) begin
            void'(data_q.pop_front());
            n_din_fire++;
        end
        if (fc) n_cmd_fire++;
        last_cmd_fire = fc;
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) data_q.push_back(wseed + 24'(k));
        wseed = wseed + 24'h001000;
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
            if (last_cmd_fire) bus.src_cmd_valid = 1'b0;
        end while ((bus.state != st) && (n < 20));
        check(name, 32'(bus.state), 32'(st));
    endtask

    task automatic finish_cmd(input string name);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.cmd_done && (n < 50));
        if (bus.cmd_done) exp_cnt++;
        check(name, 32'(bus.cmd_done), 32'd1);
    endtask

    task automatic run_cmd(input int idx, input vec_t v);
        int          c_fire, c_done, busy_n, rdy_busy, fire0, budget;
        logic        seen_issue;
        logic [7:0]  got_len;
        logic [1:0]  got_mode;
        logic [21:0] got_pause;
        push_words(int'(v.len));
        fire0 = n_din_fire;
        bits_bad = 0;
        c_fire = -1; c_done = -1; busy_n = 0; rdy_busy = 0; budget = 0;
        seen_issue = 1'b0; got_len = '0; got_mode = '0; got_pause = '0;
        bus.src_cmd_bits  = {v.pause, v.mode, v.len};
        bus.src_cmd_valid = 1'b1;
        while ((c_done < 0) && (budget < 600)) begin
            cyc();
            budget++;
            if (last_cmd_fire) begin
                c_fire = cyc_no - 1;
                bus.src_cmd_valid = 1'b0;
            end
            if (c_fire >= 0) begin
                if (bus.busy) busy_n++;
                if (bus.busy && bus.src_cmd_ready) rdy_busy++;
                if (!seen_issue && (bus.state == 2'd1)) begin
                    seen_issue = 1'b1;
                    got_len    = bus.core_cmd_length;
                    got_mode   = bus.core_cmd_mode;
                    got_pause  = bus.core_cmd_pause;
                end
                if (bus.cmd_done) c_done = cyc_no;
            end
        end
        if (c_done >= 0) exp_cnt++;
        check($sformatf("v%0d_len", idx), 32'(got_len), 32'(v.len));
        check($sformatf("v%0d_mode", idx), 32'(got_mode), 32'(v.mode));
        check($sformatf("v%0d_pause", idx), 32'(got_pause), 32'(v.pause));
        check($sformatf("v%0d_done_latency", idx), 32'(c_done - c_fire), 32'(v.exp_lat));
        check($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(v.exp_busy));
        check($sformatf("v%0d_data_fires", idx), 32'(n_din_fire - fire0), 32'(v.len));
        check($sformatf("v%0d_data_bits", idx), 32'(bits_bad), 32'd0);
        check($sformatf("v%0d_fifo_left", idx), 32'(data_q.size()), 32'd0);
        check($sformatf("v%0d_ready_busy", idx), 32'(rdy_busy), 32'd0);
        check($sformatf("v%0d_cmd_count", idx), 32'(bus.cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
        cyc();
        check($sformatf("v%0d_done_pulse", idx), 32'(bus.cmd_done), 32'd0);
    endtask

    initial begin
        int fire0;
        int cmd0;
        rstn = 1'b0;
        bus.enable = 1'b0; bus.hold = 1'b0; bus.abort = 1'b0;
        bus.src_cmd_valid = 1'b0; bus.src_cmd_bits = '0; bus.core_cmd_ready = 1'b1;
        bus.src_din_valid = 1'b0; bus.src_din_bits = '0; bus.core_din_ready = 1'b1;

        vecs[0] = '{pause: 22'd0,  mode: 2'd1, len: 8'd4,   exp_lat: 6,   exp_busy: 5};
        vecs[1] = '{pause: 22'd10, mode: 2'd0, len: 8'd2,   exp_lat: 14,  exp_busy: 13};
        vecs[2] = '{pause: 22'd0,  mode: 2'd2, len: 8'd0,   exp_lat: 2,   exp_busy: 1};
        vecs[3] = '{pause: 22'd3,  mode: 2'd3, len: 8'd0,   exp_lat: 5,   exp_busy: 4};
        vecs[4] = '{pause: 22'd1,  mode: 2'd2, len: 8'd1,   exp_lat: 4,   exp_busy: 3};
        vecs[5] = '{pause: 22'd0,  mode: 2'd0, len: 8'd255, exp_lat: 257, exp_busy: 256};

        @(negedge clk);
        cyc();
        cyc();
        bus.enable = 1'b1;
        #1;
        check("rst_src_cmd_ready", 32'(bus.src_cmd_ready), 32'd0);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_core_cmd_valid", 32'(bus.core_cmd_valid), 32'd0);
        check("rst_core_cmd_fields", {bus.core_cmd_pause, bus.core_cmd_mode, bus.core_cmd_length}, 32'd0);
        check("rst_cmd_done", 32'(bus.cmd_done), 32'd0);
        check("rst_cmd_count", 32'(bus.cmd_count), 32'd0);
        check("rst_starve_count", 32'(bus.starve_count), 32'd0);
        check("rst_core_din_valid", 32'(bus.core_din_valid), 32'd0);
        rstn = 1'b1;
        #1;
        check("post_rst_src_cmd_ready", 32'(bus.src_cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_cmd(i, vecs[i]);

        // Core ready but FIFO empty for 7 RUN cycles.
        bus.src_cmd_bits = {22'd0, 2'd0, 8'd3};
        bus.src_cmd_valid = 1'b1;
        wait_state(2'd2, "starve_reach_run");
        for (int i = 0; i < 7; i++) cyc();
        check("starve_count_7", 32'(bus.starve_count), STATS ? 32'd7 : 32'd0);
        check("starve_still_run", 32'(bus.state), 32'd2);
`ifdef OFDMBBP_SCHED_STATS_EN
        force dut.u_stats.r_starve_count = 16'hFFFE;
        #1;
        release dut.u_stats.r_starve_count;
        for (int i = 0; i < 3; i++) cyc();
        check("starve_saturate", 32'(bus.starve_count), 32'h0000FFFF);
`endif
        push_words(3);
        finish_cmd("starve_done");
        check("starve_cmd_count", 32'(bus.cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
        cyc();

        // Abort after 1 of 8 beats.
        push_words(8);
        bus.src_cmd_bits = {22'd5, 2'd2, 8'd8};
        bus.src_cmd_valid = 1'b1;
        wait_state(2'd2, "abort_reach_run");
        fire0 = n_din_fire;
        cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_no_done", 32'(bus.cmd_done), 32'd0);
        check("abort_count", 32'(bus.cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
        check("abort_fifo_left", 32'(data_q.size()), 32'd7);
        check("abort_fires", 32'(n_din_fire - fire0), 32'd1);
        cyc();
        check("abort_no_late_done", 32'(bus.cmd_done), 32'd0);
        data_q.delete();

        // Abort coinciding with the last beat.
        push_words(1);
        bus.src_cmd_bits = {22'd0, 2'd1, 8'd1};
        bus.src_cmd_valid = 1'b1;
        wait_state(2'd2, "abort_last_reach_run");
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        check("abort_last_state", 32'(bus.state), 32'd0);
        check("abort_last_fifo", 32'(data_q.size()), 32'd1);
        cyc();
        check("abort_last_no_done", 32'(bus.cmd_done), 32'd0);
        check("abort_last_count", 32'(bus.cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
        data_q.delete();

        // Hold blocks fetch; release accepts within one cycle; core_cmd_ready low keeps ISSUE.
        bus.hold = 1'b1;
        push_words(1);
        bus.src_cmd_bits = {22'd0, 2'd3, 8'd1};
        bus.src_cmd_valid = 1'b1;
        #1;
        check("hold_ready_low", 32'(bus.src_cmd_ready), 32'd0);
        for (int i = 0; i < 3; i++) cyc();
        check("hold_stay_idle", 32'(bus.state), 32'd0);
        bus.hold = 1'b0;
        #1;
        check("hold_release_ready", 32'(bus.src_cmd_ready), 32'd1);
        bus.core_cmd_ready = 1'b0;
        cyc();
        check("hold_accept", 32'(last_cmd_fire), 32'd1);
        bus.src_cmd_valid = 1'b0;
        check("hold_issue", 32'(bus.state), 32'd1);
        cyc();
        cyc();
        check("issue_wait_state", 32'(bus.state), 32'd1);
        check("issue_wait_valid", 32'(bus.core_cmd_valid), 32'd1);
        bus.core_cmd_ready = 1'b1;
        finish_cmd("hold_done");

        // Enable dropped mid-command: finish it, then stay idle with a command pending.
        push_words(2);
        bus.src_cmd_bits = {22'd0, 2'd0, 8'd2};
        bus.src_cmd_valid = 1'b1;
        wait_state(2'd2, "en_reach_run");
        bus.enable = 1'b0;
        bus.src_cmd_bits = {22'd0, 2'd0, 8'd0};
        bus.src_cmd_valid = 1'b1;
        cmd0 = n_cmd_fire;
        finish_cmd("en_off_done");
        for (int i = 0; i < 3; i++) cyc();
        check("en_off_idle", 32'(bus.state), 32'd0);
        check("en_off_no_fetch", 32'(n_cmd_fire - cmd0), 32'd0);
        check("en_off_ready", 32'(bus.src_cmd_ready), 32'd0);
        check("final_cmd_count", 32'(bus.cmd_count), STATS ? 32'(exp_cnt) : 32'd0);
        bus.src_cmd_valid = 1'b0;
        bus.enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
